// File: rtl/vip_ctrl_pkt_gen_pkg.sv
// rtl/vip_ctrl_pkt_gen_pkg.sv - VIP packet types, control-packet constants and frame config struct
package vip_pkg;

  localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;
  localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
  localparam int         CTRL_NIBBLES   = 9;

  typedef struct packed {
    logic [15:0] width;
    logic [15:0] height;
    logic [3:0]  interlace;
  } vip_frame_cfg_t;

  // Header beat plus the nine payload nibbles packed spb per beat.
  function automatic int ctrl_num_beats(input int spb);
    return 1 + (CTRL_NIBBLES + spb - 1) / spb;
  endfunction

endpackage

// File: rtl/vip_ctrl_pkt_gen_if.sv
// rtl/vip_ctrl_pkt_gen_if.sv - Avalon-ST source stream carrying VIP packet beats
interface vip_ctrl_pkt_gen_if #(
  parameter int DATA_W = 24
) ();

  logic [DATA_W-1:0] src_data;
  logic              src_valid;
  logic              src_sop;
  logic              src_eop;
  logic              src_ready;

  modport master (output src_data, src_valid, src_sop, src_eop, input src_ready);
  modport slave  (input src_data, src_valid, src_sop, src_eop, output src_ready);

endinterface

// File: rtl/vip_ctrl_pkt_gen_nib_pack.sv
// rtl/vip_ctrl_pkt_gen_nib_pack.sv - combinational beat builder for VIP control packets
module vip_ctrl_nib_pack
  import vip_pkg::*;
#(
  parameter int BPS = 8,
  parameter int SPB = 3
) (
  input  logic [3:0]         beat,
  input  vip_frame_cfg_t     cfg,
  output logic [BPS*SPB-1:0] data
);

  logic [3:0] nibs [CTRL_NIBBLES];

  assign nibs[0] = cfg.width[15:12];
  assign nibs[1] = cfg.width[11:8];
  assign nibs[2] = cfg.width[7:4];
  assign nibs[3] = cfg.width[3:0];
  assign nibs[4] = cfg.height[15:12];
  assign nibs[5] = cfg.height[11:8];
  assign nibs[6] = cfg.height[7:4];
  assign nibs[7] = cfg.height[3:0];
  assign nibs[8] = cfg.interlace;

  // Symbol s of payload beat b carries nibble (b-1)*SPB+s; past the last nibble it stays zero.
  always_comb begin
    data = '0;
    for (int s = 0; s < SPB; s++) begin
      if (beat == 4'd0) begin
        if (s == 0) data[3:0] = PKT_TYPE_CTRL;
      end else begin
        for (int k = 0; k < CTRL_NIBBLES; k++) begin
          if ((int'(beat) - 1) * SPB + s == k) data[s*BPS +: 4] = nibs[k];
        end
      end
    end
  end

endmodule

// File: rtl/vip_ctrl_pkt_gen.sv
// rtl/vip_ctrl_pkt_gen.sv - VIP control-packet generator with one-deep pending config
// Optional resend on frame_tick is enabled by VIP_CTRL_RESEND_EN.
module vip_ctrl_pkt_gen
  import vip_pkg::*;
#(
  parameter int BPS = 8,
  parameter int SPB = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  input  logic [15:0]         cfg_width,
  input  logic [15:0]         cfg_height,
  input  logic [3:0]          cfg_interlace,
  vip_ctrl_pkt_gen_if.master  src,
  output logic                busy,
  output logic                pkt_done
`ifdef VIP_CTRL_RESEND_EN
  ,
  input  logic                frame_tick
`endif
);

  localparam int         DATA_W    = BPS * SPB;
  localparam int         NBEATS    = ctrl_num_beats(SPB);
  localparam logic [3:0] LAST_BEAT = 4'(NBEATS - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]        state;
  logic [3:0]        beat;
  vip_frame_cfg_t    active;
  vip_frame_cfg_t    pend_cfg;
  vip_frame_cfg_t    cfg_in;
  logic              pend;
  logic              accept;
  logic              eop_acc;
  logic              start_resend;
  logic [DATA_W-1:0] beat_data;

  assign cfg_in  = {cfg_width, cfg_height, cfg_interlace};
  assign accept  = src.src_valid & src.src_ready;
  assign eop_acc = accept & (beat == LAST_BEAT);

`ifdef VIP_CTRL_RESEND_EN
  logic cfg_seen;
  assign start_resend = frame_tick & cfg_seen;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         cfg_seen <= 1'b0;
    else if (cfg_valid) cfg_seen <= 1'b1;
  end
`else
  assign start_resend = 1'b0;
`endif

  vip_ctrl_nib_pack #(.BPS(BPS), .SPB(SPB)) u_pack (
    .beat (beat),
    .cfg  (active),
    .data (beat_data)
  );

  assign src.src_valid = (state == ST_SEND);
  assign src.src_sop   = src.src_valid & (beat == 4'd0);
  assign src.src_eop   = src.src_valid & (beat == LAST_BEAT);
  assign src.src_data  = src.src_valid ? beat_data : '0;
  assign busy          = (state == ST_SEND) | pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      beat     <= 4'd0;
      active   <= '0;
      pend_cfg <= '0;
      pend     <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= eop_acc;
      case (state)
        ST_IDLE: begin
          beat <= 4'd0;
          if (cfg_valid) begin
            active <= cfg_in;
            state  <= ST_SEND;
          end else if (start_resend) begin
            state  <= ST_SEND;
          end
        end
        default: begin
          if (eop_acc) begin
            beat <= 4'd0;
            // A config arriving with the EOP is newer than anything pending, so it goes next.
            if (cfg_valid) begin
              active <= cfg_in;
              pend   <= 1'b0;
            end else if (pend) begin
              active <= pend_cfg;
              pend   <= 1'b0;
            end else begin
              state  <= ST_IDLE;
            end
          end else begin
            if (accept) beat <= beat + 4'd1;
            if (cfg_valid) begin
              pend_cfg <= cfg_in;
              pend     <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
